uart_fifo_core: RTL and testbench
=================================

# uart_fifo_core

Parametrised successor to the UART top level: an oversampling UART receiver and transmitter with a shared baud-tick generator and independent RX/TX FIFOs. It exposes a simple read/write FIFO interface to the debug unit or MIPS bus side. Frame width, stop bits, FIFO depth and baud divisor are configurable. It also reports sticky framing and overrun errors, which the previous fixed 8N1 single-buffer UART could not do.

## Interface
- DIVISOR, 27: clk cycles per 16x-oversample tick (≥2).
- DATA_BITS, 8: payload bits per frame (5..8).
- STOP_BITS, 1: stop bits transmitted (1 or 2); RX always checks one.
- FIFO_DEPTH, 16: entries per FIFO (power of 2, ≥2).
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  serial input (idle high), passed through a 2-flop synchroniser
- tx  out  1  serial output (idle high)
- wr  in  1  push w_data into TX FIFO
- w_data  in  DATA_BITS  byte to transmit
- tx_full  out  1  TX FIFO full
- rd  in  1  pop RX FIFO head
- r_data  out  DATA_BITS  RX FIFO head (show-ahead)
- rx_empty  out  1  RX FIFO empty
- clr_err  in  1  clears all sticky error flags
- frame_err  out  1  sticky: a stop bit was sampled low
- overrun  out  1  sticky: a byte was received while the RX FIFO was full
- parity_err  out  1  sticky: parity mismatch (present only with UART_PARITY_EN)

## Operation
- Tick: a counter runs 0..DIVISOR-1; `tick` pulses for 1 clk at terminal count.
- RX FSM has states IDLE, START, DATA, PARITY, STOP.
  - IDLE→START on synchronised rx=0.
  - START: after 8 ticks, re-sample rx. If low → DATA; if high → IDLE (glitch, nothing pushed).
  - DATA: sample every 16 ticks, LSB first, DATA_BITS samples. Then → PARITY (if enabled) or STOP.
  - STOP: sample after 16 ticks, then push the byte and return to IDLE.
    - If the sample is 0: set frame_err; the byte is still pushed.
    - If the RX FIFO is full: drop the byte and set overrun.
- TX FSM has states IDLE, START, DATA, PARITY, STOP.
  - IDLE: when the TX FIFO is non-empty, pop the head into a shift register → START.
  - START: drive tx=0 for 16 ticks.
  - DATA: drive each bit for 16 ticks, LSB first.
  - PARITY: 16 ticks (if enabled).
  - STOP: tx=1 for 16·STOP_BITS ticks → IDLE.
  - Back-to-back frames follow with no idle gap.
- FIFOs use pointers with one extra wrap bit. Full when the low bits are equal and the wrap bits differ; empty when the pointers are equal.
  - wr while full: ignored, FIFO unchanged.
  - rd while empty: ignored, r_data unchanged.
  - Simultaneous rd+wr on a non-empty, non-full FIFO: both occur, count unchanged.
  - Simultaneous rd+wr when full: the read succeeds and the write is dropped.
  - Simultaneous rd+wr when empty: the write succeeds and the read is ignored.
- clr_err has priority over a same-cycle error set: the flags clear, and the event that cycle is lost.

## Timing
- Reset values: tx=1, tx_full=0, rx_empty=1, r_data=0, all error flags 0, both FSMs IDLE, FIFOs empty, tick counter 0.
- Reset asserted mid-frame aborts immediately: tx goes high and all FIFO contents are discarded.
- wr→tx_full and rd→rx_empty update on the next clk edge. r_data reflects the new head one cycle after rd.
- TX: first start-bit edge on tx appears ≤ 16·DIVISOR+2 clk after wr into an empty idle TX FIFO.
- Frame length: (1+DATA_BITS+P+STOP_BITS)·16·DIVISOR clk, where P=1 with parity enabled, else 0.
- RX push: rx_empty falls 1 clk after the stop-bit mid-sample tick.

## Configuration
- UART_PARITY_EN defined:
  - Even parity bit is sent after the data bits and checked on receive.
  - A mismatch sets parity_err; the byte is still pushed.
- UART_PARITY_EN undefined:
  - No parity state, no parity_err port.
  - Frames are DATA_BITS N STOP_BITS.

## Structure
- Shared package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - OVERSAMPLE=16 and MID_SAMPLE=8;
  - the pointer-width function clog2(FIFO_DEPTH).
- One sub-module, uart_fifo (parameters WIDTH, DEPTH), instantiated twice.
- Tick generator and both FSMs live in the top module.

## Test plan
- DIVISOR=4, 8N1: write 0xA5 → tx shows 0, bits 1,0,1,0,0,1,0,1, then 1; each bit lasts 64 clk.
- Loop tx→rx, write 0x00, 0xFF, 0x3C back-to-back → RX FIFO reads 0x00, 0xFF, 0x3C in order; no errors.
- Fill TX FIFO with 16 writes → tx_full=1; a 17th write is ignored; exactly 16 frames are transmitted.
- Receive 17 frames without rd (FIFO_DEPTH=16) → overrun=1, FIFO holds the first 16. clr_err → overrun=0.
- Drive rx with stop bit=0 on 0x55 → frame_err=1, r_data=0x55. A 3-clk-tick low glitch on idle rx → no push.
- UART_PARITY_EN, send 0x07 with parity bit 0 → parity_err=1. Assert rst_n low mid-TX-frame → tx=1 and tx_full=0 immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART FIFO core.
//   uart_state_e : state encoding used by both the RX and TX frame FSMs
//   OVERSAMPLE   : baud ticks per serial bit
//   MID_SAMPLE   : ticks from the start-bit edge to its centre
//   clog2()      : pointer/counter width helper
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    // Bits needed to index 'value' entries (minimum 1).
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/uart_fifo_core_if.sv
// -----------------------------------------------------------------------------
// uart_fifo_core_if
// Bus-side FIFO interface of the UART core (debug unit / MIPS bus).
//   wr, w_data  : push a byte into the TX FIFO
//   tx_full     : TX FIFO full
//   rd          : pop the RX FIFO head
//   r_data      : RX FIFO head (show-ahead)
//   rx_empty    : RX FIFO empty
//   clr_err     : clear all sticky error flags
//   frame_err   : sticky stop-bit error
//   overrun     : sticky RX overflow
//   parity_err  : sticky parity error (only with UART_PARITY_EN)
// master = bus side, slave = UART core.
// -----------------------------------------------------------------------------
interface uart_fifo_core_if #(
    parameter int DATA_BITS = 8
);
    logic                 wr;
    logic [DATA_BITS-1:0] w_data;
    logic                 tx_full;
    logic                 rd;
    logic [DATA_BITS-1:0] r_data;
    logic                 rx_empty;
    logic                 clr_err;
    logic                 frame_err;
    logic                 overrun;
`ifdef UART_PARITY_EN
    logic                 parity_err;

    modport master (
        output wr, w_data, rd, clr_err,
        input  tx_full, r_data, rx_empty, frame_err, overrun, parity_err
    );

    modport slave (
        input  wr, w_data, rd, clr_err,
        output tx_full, r_data, rx_empty, frame_err, overrun, parity_err
    );
`else
    modport master (
        output wr, w_data, rd, clr_err,
        input  tx_full, r_data, rx_empty, frame_err, overrun
    );

    modport slave (
        input  wr, w_data, rd, clr_err,
        output tx_full, r_data, rx_empty, frame_err, overrun
    );
`endif

endinterface

// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
// Synchronous FIFO with wrap-bit pointers and a registered show-ahead head.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr, w_data : push (ignored while full, even with a same-cycle rd)
//   rd         : pop  (ignored while empty, even with a same-cycle wr)
//   r_data     : current head, held unchanged while the FIFO is empty
//   full       : low pointer bits equal, wrap bits differ
//   empty      : pointers equal
// -----------------------------------------------------------------------------
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [WIDTH-1:0] w_data,
    input  logic             rd,
    output logic [WIDTH-1:0] r_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nxt;
    logic [AW:0]      rd_ptr_nxt;
    logic             do_wr;
    logic             do_rd;
    logic [WIDTH-1:0] head_nxt;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;

    assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_wr};
    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_rd};

    // Head after this cycle's operations. A write landing in the slot that
    // becomes the head must forward w_data, since mem is not yet updated.
    always_comb begin
        // NOTE: default first so every path assigns head_nxt and no latch is inferred.
        head_nxt = r_data;
        if (wr_ptr_nxt != rd_ptr_nxt) begin
            if (do_wr && (rd_ptr_nxt[AW-1:0] == wr_ptr[AW-1:0])) begin
                head_nxt = w_data;
            end else begin
                head_nxt = mem[rd_ptr_nxt[AW-1:0]];
            end
        end
    end

    // NOTE: storage array is deliberately left out of reset; only pointers and
    // the head register need defined values, and an unreset array maps to RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= w_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            r_data <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            r_data <= head_nxt;
        end
    end

endmodule

// File: rtl/uart_fifo_core.sv
// -----------------------------------------------------------------------------
// uart_fifo_core
// Oversampling UART receiver and transmitter sharing one baud-tick generator,
// each buffered by its own uart_fifo.
//   clk, rst_n : system clock, asynchronous active-low reset
//   rx         : serial input, idle high (2-flop synchronised)
//   tx         : serial output, idle high
//   bus        : uart_fifo_core_if.slave (FIFO access and sticky errors)
// Parameters: DIVISOR (clk per 16x tick, >=2), DATA_BITS (5..8),
//   STOP_BITS (1 or 2, TX only), FIFO_DEPTH (power of 2, >=2).
// Optional feature: define UART_PARITY_EN for an even parity bit on TX,
//   parity checking on RX and the sticky parity_err flag.
// -----------------------------------------------------------------------------
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int DIVISOR    = 27,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx,
    output logic               tx,
    uart_fifo_core_if.slave    bus
);

    localparam int              DIV_W       = clog2(DIVISOR);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIVISOR - 1);
    localparam logic [3:0]      SAMPLE_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]      MID_LAST    = 4'(MID_SAMPLE - 1);
    localparam logic [3:0]      DATA_LAST   = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST   = 4'(STOP_BITS - 1);

    // ---------------------------------------------------------------- ticks
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------ receiver
    logic                 rx_meta;
    logic                 rx_sync;
    uart_state_e          rx_state;
    logic [3:0]           rx_tick_cnt;
    logic [3:0]           rx_bit_cnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_sample;
    logic                 rx_push;
    logic                 rx_full;
`ifdef UART_PARITY_EN
    logic                 rx_par_bit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Bit-centre sample point (16 ticks after the previous centre).
    assign rx_sample = tick && (rx_tick_cnt == SAMPLE_LAST);
    // Push happens on the stop-bit centre tick so rx_empty falls on the next edge.
    assign rx_push   = (rx_state == STOP) && rx_sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state    <= IDLE;
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_shift    <= '0;
`ifdef UART_PARITY_EN
            rx_par_bit  <= 1'b0;
`endif
        end else begin
            case (rx_state)
                IDLE: begin
                    rx_tick_cnt <= '0;
                    if (!rx_sync) begin
                        rx_state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (rx_tick_cnt == MID_LAST) begin
                            // Line back high at start-bit centre: treat as glitch.
                            rx_tick_cnt <= '0;
                            rx_bit_cnt  <= '0;
                            rx_state    <= rx_sync ? IDLE : DATA;
                        end else begin
                            rx_tick_cnt <= rx_tick_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (rx_sample) begin
                        rx_tick_cnt <= '0;
                        rx_shift    <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit_cnt == DATA_LAST) begin
                            rx_bit_cnt <= '0;
`ifdef UART_PARITY_EN
                            rx_state   <= PARITY;
`else
                            rx_state   <= STOP;
`endif
                        end else begin
                            rx_bit_cnt <= rx_bit_cnt + 4'd1;
                        end
                    end else if (tick) begin
                        rx_tick_cnt <= rx_tick_cnt + 4'd1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (rx_sample) begin
                        rx_tick_cnt <= '0;
                        rx_par_bit  <= rx_sync;
                        rx_state    <= STOP;
                    end else if (tick) begin
                        rx_tick_cnt <= rx_tick_cnt + 4'd1;
                    end
                end
`endif
                STOP: begin
                    if (rx_sample) begin
                        rx_tick_cnt <= '0;
                        rx_state    <= IDLE;
                    end else if (tick) begin
                        rx_tick_cnt <= rx_tick_cnt + 4'd1;
                    end
                end
                default: begin
                    rx_state    <= IDLE;
                    rx_tick_cnt <= '0;
                end
            endcase
        end
    end

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr     (rx_push),
        .w_data (rx_shift),
        .rd     (bus.rd),
        .r_data (bus.r_data),
        .full   (rx_full),
        .empty  (bus.rx_empty)
    );

    // -------------------------------------------------------- sticky errors
    logic frame_err_q;
    logic overrun_q;
`ifdef UART_PARITY_EN
    logic parity_err_q;
`endif

    // clr_err wins over a same-cycle error event; that event is not recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else if (bus.clr_err) begin
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            if (rx_push && !rx_sync) begin
                frame_err_q <= 1'b1;
            end
            if (rx_push && rx_full) begin
                overrun_q <= 1'b1;
            end
`ifdef UART_PARITY_EN
            if (rx_push && (rx_par_bit != ^rx_shift)) begin
                parity_err_q <= 1'b1;
            end
`endif
        end
    end

    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
`ifdef UART_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif

    // --------------------------------------------------------- transmitter
    uart_state_e          tx_state;
    logic [3:0]           tx_tick_cnt;
    logic [3:0]           tx_bit_cnt;
    logic [DATA_BITS-1:0] tx_shift;
    logic [DATA_BITS-1:0] tx_head;
    logic                 tx_empty;
    logic                 tx_bit_done;
    logic                 tx_pop;
    logic                 tx_q;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    assign tx_bit_done = tick && (tx_tick_cnt == SAMPLE_LAST);
    // Frames start on a tick so every bit lasts exactly 16 ticks; the last
    // stop-bit tick also starts the next frame, leaving no idle gap.
    assign tx_pop = !tx_empty &&
                    (((tx_state == IDLE) && tick) ||
                     ((tx_state == STOP) && tx_bit_done && (tx_bit_cnt == STOP_LAST)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state    <= IDLE;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_shift    <= '0;
            tx_q        <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par      <= 1'b0;
`endif
        end else begin
            case (tx_state)
                IDLE: begin
                    tx_q        <= 1'b1;
                    tx_tick_cnt <= '0;
                    if (tx_pop) begin
                        tx_shift <= tx_head;
                        tx_q     <= 1'b0;
                        tx_state <= START;
`ifdef UART_PARITY_EN
                        tx_par   <= ^tx_head;
`endif
                    end
                end
                START: begin
                    if (tx_bit_done) begin
                        tx_tick_cnt <= '0;
                        tx_bit_cnt  <= '0;
                        tx_q        <= tx_shift[0];
                        tx_state    <= DATA;
                    end else if (tick) begin
                        tx_tick_cnt <= tx_tick_cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (tx_bit_done) begin
                        tx_tick_cnt <= '0;
                        if (tx_bit_cnt == DATA_LAST) begin
                            tx_bit_cnt <= '0;
`ifdef UART_PARITY_EN
                            tx_q       <= tx_par;
                            tx_state   <= PARITY;
`else
                            tx_q       <= 1'b1;
                            tx_state   <= STOP;
`endif
                        end else begin
                            tx_bit_cnt <= tx_bit_cnt + 4'd1;
                            tx_shift   <= tx_shift >> 1;
                            tx_q       <= tx_shift[1];
                        end
                    end else if (tick) begin
                        tx_tick_cnt <= tx_tick_cnt + 4'd1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (tx_bit_done) begin
                        tx_tick_cnt <= '0;
                        tx_bit_cnt  <= '0;
                        tx_q        <= 1'b1;
                        tx_state    <= STOP;
                    end else if (tick) begin
                        tx_tick_cnt <= tx_tick_cnt + 4'd1;
                    end
                end
`endif
                STOP: begin
                    if (tx_bit_done) begin
                        tx_tick_cnt <= '0;
                        if (tx_bit_cnt == STOP_LAST) begin
                            tx_bit_cnt <= '0;
                            if (tx_pop) begin
                                tx_shift <= tx_head;
                                tx_q     <= 1'b0;
                                tx_state <= START;
`ifdef UART_PARITY_EN
                                tx_par   <= ^tx_head;
`endif
                            end else begin
                                tx_state <= IDLE;
                            end
                        end else begin
                            tx_bit_cnt <= tx_bit_cnt + 4'd1;
                        end
                    end else if (tick) begin
                        tx_tick_cnt <= tx_tick_cnt + 4'd1;
                    end
                end
                default: begin
                    tx_state <= IDLE;
                    tx_q     <= 1'b1;
                end
            endcase
        end
    end

    assign tx = tx_q;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr     (bus.wr),
        .w_data (bus.w_data),
        .rd     (tx_pop),
        .r_data (tx_head),
        .full   (bus.tx_full),
        .empty  (tx_empty)
    );

endmodule

// File: tb/tb_uart_fifo_core.sv
// -----------------------------------------------------------------------------
// tb_uart_fifo_core
// Directed bench for uart_fifo_core (DIVISOR=4, 8 data bits, 1 stop bit,
// 16-entry FIFOs). Works with and without UART_PARITY_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_fifo_core;

    localparam int DIVISOR    = 4;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int FIFO_DEPTH = 16;
`ifdef UART_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int BIT_CLK    = 16 * DIVISOR;
    localparam int FRAME_BITS = 1 + DATA_BITS + PBITS + STOP_BITS;
    localparam int FRAME_CLK  = FRAME_BITS * BIT_CLK;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_drv;
    logic loop_en;
    logic rx;
    logic tx;

    assign rx = loop_en ? tx : rx_drv;

    uart_fifo_core_if #(.DATA_BITS(DATA_BITS)) bus ();

    uart_fifo_core #(
        .DIVISOR    (DIVISOR),
        .DATA_BITS  (DATA_BITS),
        .STOP_BITS  (STOP_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .tx    (tx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_frame_err;
        logic       exp_overrun;
    } rx_vec_t;

    rx_vec_t vecs [4];
    logic    exp_bits [FRAME_BITS];
    logic    smp [FRAME_CLK+1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tx_write(input logic [7:0] b);
        bus.w_data = b;
        bus.wr     = 1'b1;
        @(negedge clk);
        bus.wr     = 1'b0;
    endtask

    task automatic rx_pop_check(input string name, input logic [7:0] exp);
        check(name, bus.r_data, exp);
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
    endtask

    // Serial frame on rx; stop_clk shortens a bad stop bit so the line is
    // back high well before the next frame.
    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stop, input int stop_clk);
        rx_drv = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx_drv = d[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        if (PBITS == 1) begin
            rx_drv = par;
            repeat (BIT_CLK) @(negedge clk);
        end
        rx_drv = stop;
        repeat (stop_clk) @(negedge clk);
        rx_drv = 1'b1;
        repeat (BIT_CLK + 40) @(negedge clk);
    endtask

    task automatic wait_tx_low(input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         found;
        int         falls;
        logic       prev;
        logic [7:0] a5;

        // Vectors: data, stop bit driven, expected head, frame_err, overrun.
        vecs[0] = '{8'h81, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[1] = '{8'h55, 1'b0, 8'h55, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[3] = '{8'hE6, 1'b0, 8'hE6, 1'b1, 1'b0};

        rst_n       = 1'b0;
        rx_drv      = 1'b1;
        loop_en     = 1'b0;
        bus.wr      = 1'b0;
        bus.w_data  = '0;
        bus.rd      = 1'b0;
        bus.clr_err = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---- reset state
        check("rst_tx", tx, 1);
        check("rst_tx_full", bus.tx_full, 0);
        check("rst_rx_empty", bus.rx_empty, 1);
        check("rst_r_data", bus.r_data, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_overrun", bus.overrun, 0);
`ifdef UART_PARITY_EN
        check("rst_parity_err", bus.parity_err, 0);
`endif

        // ---- TX waveform of 0xA5
        a5 = 8'hA5;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) exp_bits[1+i] = a5[i];
        if (PBITS == 1) exp_bits[1+DATA_BITS] = ^a5;
        for (int i = 1 + DATA_BITS + PBITS; i < FRAME_BITS; i++) exp_bits[i] = 1'b1;

        tx_write(8'hA5);
        wait_tx_low(16 * DIVISOR + 2, found);
        check("a5_start_latency", found, 1);
        if (found) begin
            smp[0] = tx;
            for (int i = 1; i <= FRAME_CLK; i++) begin
                @(negedge clk);
                smp[i] = tx;
            end
            for (int k = 0; k < FRAME_BITS; k++) begin
                check($sformatf("a5_bit%0d", k), smp[k*BIT_CLK + BIT_CLK/2], exp_bits[k]);
            end
            check("a5_start_last_clk", smp[BIT_CLK-1], 0);
            check("a5_bit0_first_clk", smp[BIT_CLK], exp_bits[1]);
            check("a5_stop_last_clk", smp[FRAME_CLK-1], 1);
            check("a5_idle_after", smp[FRAME_CLK], 1);
        end
        repeat (BIT_CLK) @(negedge clk);

        // ---- loopback of back-to-back frames
        loop_en = 1'b1;
        tx_write(8'h00);
        tx_write(8'hFF);
        tx_write(8'h3C);
        repeat (3 * FRAME_CLK + 200) @(negedge clk);
        check("loop_rx_not_empty", bus.rx_empty, 0);
        rx_pop_check("loop_byte0", 8'h00);
        rx_pop_check("loop_byte1", 8'hFF);
        rx_pop_check("loop_byte2", 8'h3C);
        check("loop_rx_empty", bus.rx_empty, 1);
        check("loop_frame_err", bus.frame_err, 0);
        check("loop_overrun", bus.overrun, 0);
        loop_en = 1'b0;
        repeat (BIT_CLK) @(negedge clk);

        // ---- table-driven RX frames (good and bad stop bits)
        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].data, ^vecs[v].data, vecs[v].stop,
                       vecs[v].stop ? BIT_CLK : 48);
            check($sformatf("vec%0d_rx_empty", v), bus.rx_empty, 0);
            check($sformatf("vec%0d_frame_err", v), bus.frame_err, vecs[v].exp_frame_err);
            check($sformatf("vec%0d_overrun", v), bus.overrun, vecs[v].exp_overrun);
            rx_pop_check($sformatf("vec%0d_r_data", v), vecs[v].exp_data);
            check($sformatf("vec%0d_drained", v), bus.rx_empty, 1);
            pulse_clr();
            check($sformatf("vec%0d_cleared", v), bus.frame_err, 0);
        end

        // ---- short low glitch on idle rx
        rx_drv = 1'b0;
        repeat (3 * DIVISOR) @(negedge clk);
        rx_drv = 1'b1;
        repeat (FRAME_CLK) @(negedge clk);
        check("glitch_no_push", bus.rx_empty, 1);
        check("glitch_no_frame_err", bus.frame_err, 0);

        // ---- RX overrun: 17 frames, no reads
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            send_frame(8'h10 + 8'(i), ^(8'h10 + 8'(i)), 1'b1, BIT_CLK);
            if (i == FIFO_DEPTH - 1) check("ovr_not_yet", bus.overrun, 0);
        end
        check("ovr_set", bus.overrun, 1);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            rx_pop_check($sformatf("ovr_entry%0d", i), 8'h10 + 8'(i));
        end
        check("ovr_drained", bus.rx_empty, 1);
        check("ovr_frame_err", bus.frame_err, 0);
        pulse_clr();
        check("ovr_cleared", bus.overrun, 0);

        // ---- TX FIFO fill: one frame in flight, 16 queued, 17th dropped.
        // 0xFE gives exactly one falling edge per frame in both builds.
        tx_write(8'hFE);
        wait_tx_low(16 * DIVISOR + 2, found);
        check("fill_first_start", found, 1);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (i == FIFO_DEPTH - 1) check("fill_not_full_15", bus.tx_full, 0);
            tx_write(8'hFE);
        end
        check("fill_full", bus.tx_full, 1);
        tx_write(8'hFE);
        check("fill_full_after_17th", bus.tx_full, 1);
        falls = 0;
        prev  = tx;
        for (int i = 0; i < 17 * FRAME_CLK + 200; i++) begin
            @(negedge clk);
            if (prev === 1'b1 && tx === 1'b0) falls++;
            prev = tx;
        end
        check("fill_queued_frames", falls, FIFO_DEPTH);
        check("fill_drained", bus.tx_full, 0);
        check("fill_tx_idle", tx, 1);

`ifdef UART_PARITY_EN
        // ---- bad parity on 0x07 (even parity bit should be 1)
        send_frame(8'h07, 1'b0, 1'b1, BIT_CLK);
        check("par_err_set", bus.parity_err, 1);
        check("par_frame_err", bus.frame_err, 0);
        rx_pop_check("par_r_data", 8'h07);
        pulse_clr();
        check("par_err_cleared", bus.parity_err, 0);
`endif

        // ---- reset in the middle of a TX frame with a full TX FIFO
        tx_write(8'h00);
        wait_tx_low(16 * DIVISOR + 2, found);
        check("mid_rst_start", found, 1);
        for (int i = 0; i < FIFO_DEPTH; i++) tx_write(8'h00);
        repeat (100) @(negedge clk);
        check("mid_rst_tx_low_before", tx, 0);
        check("mid_rst_full_before", bus.tx_full, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_high", tx, 1);
        check("mid_rst_tx_full", bus.tx_full, 0);
        check("mid_rst_rx_empty", bus.rx_empty, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        check("post_rst_tx_idle", tx, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
